cram_read_arbiter: RTL and testbench

- Shares the single AXI4 read channel of the CRAM between two requesters: port 0 is instruction fetch (the scheduler) and port 1 is the data/loader path.
- Accepts only single-beat 32-bit reads.
- Issues AR requests through a registered stage.
- Returns each R beat to the requester that issued it, using an in-order grant FIFO checked against the ID.
- Sits between the core-side masters and the CRAM slave port.

---
 rtl/cram_read_arbiter.sv | 156 +++++++++++++++
 tb/tb_cram_read_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_read_arbiter.sv
// cram_read_arbiter: shares the CRAM AXI4 read channel between fetch (m0) and loader (m1).
// Optional CRAM_ARB_RR_EN selects round-robin arbitration; CRAM side uses arlen=0, arsize=2, INCR.
module cram_read_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              m0_araddr,
  input  logic                           m0_arvalid,
  output logic                           m0_arready,
  output logic [DATA_W-1:0]              m0_rdata,
  output logic [1:0]                     m0_rresp,
  output logic                           m0_rvalid,
  input  logic                           m0_rready,
  input  logic [ADDR_W-1:0]              m1_araddr,
  input  logic                           m1_arvalid,
  output logic                           m1_arready,
  output logic [DATA_W-1:0]              m1_rdata,
  output logic [1:0]                     m1_rresp,
  output logic                           m1_rvalid,
  input  logic                           m1_rready,
  output logic [ADDR_W-1:0]              s_araddr,
  output logic [3:0]                     s_arid,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  input  logic [DATA_W-1:0]              s_rdata,
  input  logic [3:0]                     s_rid,
  input  logic [1:0]                     s_rresp,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  output logic [$clog2(ORDER_DEPTH):0]   o_outstanding,
  output logic                           o_err
);

  localparam int PW = $clog2(ORDER_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(ORDER_DEPTH);

  logic              slot_v;
  logic [ADDR_W-1:0] slot_addr;
  logic              slot_id;

  logic [ORDER_DEPTH-1:0] ord_q;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          cnt_q;
  logic                   err_q;

  logic ar_hs;
  logic slot_free;
  logic room;
  logic can_grant;
  logic grant;
  logic pick1;
  logic empty;
  logic head;
  logic pop;
  logic unused_rid;

  assign unused_rid = ^s_rid[3:1];

  assign ar_hs     = slot_v & s_arready;
  assign slot_free = ~slot_v | s_arready;
  assign room      = ({1'b0, cnt_q} + {{CW{1'b0}}, ar_hs}) < DEPTH_V;
  assign can_grant = ~rst & slot_free & room;
  assign grant     = can_grant & (m0_arvalid | m1_arvalid);

`ifdef CRAM_ARB_RR_EN
  logic prio_q;

  // Hand priority to the other port after every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (grant) begin
      prio_q <= ~pick1;
    end
  end

  assign pick1 = m1_arvalid & (~m0_arvalid | prio_q);
`else
  assign pick1 = m1_arvalid & ~m0_arvalid;
`endif

  assign m0_arready = grant & ~pick1;
  assign m1_arready = grant & pick1;

  assign s_arvalid = slot_v;
  assign s_araddr  = slot_addr;
  assign s_arid    = {3'b000, slot_id};

  assign empty = (cnt_q == '0);
  assign head  = ord_q[rd_ptr];

  assign s_rready  = empty | (head ? m1_rready : m0_rready);
  assign pop       = s_rvalid & ~empty & s_rready;
  assign m0_rvalid = s_rvalid & ~empty & ~head;
  assign m1_rvalid = s_rvalid & ~empty & head;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m1_rresp  = s_rresp;

  assign o_outstanding = cnt_q;
  assign o_err         = err_q;

  // AR slot: load the winner, hold until the CRAM accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v    <= 1'b0;
      slot_addr <= '0;
      slot_id   <= 1'b0;
    end else if (grant) begin
      slot_v    <= 1'b1;
      slot_addr <= pick1 ? m1_araddr : m0_araddr;
      slot_id   <= pick1;
    end else if (ar_hs) begin
      slot_v    <= 1'b0;
    end
  end

  // Order FIFO: push port index on AR handshake, pop on R handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ord_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (ar_hs) begin
        ord_q[wr_ptr] <= slot_id;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({ar_hs, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error on ID mismatch or a beat with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((s_rvalid & empty) | (pop & (s_rid[0] != head))) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cram_read_arbiter.sv
// tb_cram_read_arbiter: directed bench with an in-order routing scoreboard.
// Build with +define+CRAM_ARB_RR_EN to check round-robin arbitration.
module tb_cram_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rready, m1_rready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [3:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic [2:0]  o_outstanding;
  logic        o_err;

  int vectors = 0;
  int miscompares = 0;
  int exp_port[$];
  int seq[4];

  always #5 clk = ~clk;

  cram_read_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Check the beat currently presented against the scoreboard head.
  task automatic rcheck(input logic [31:0] data, input logic [1:0] resp);
    int p;
    if (exp_port.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    p = exp_port.pop_front();
    chk("r_m0_valid", m0_rvalid, p == 0);
    chk("r_m1_valid", m1_rvalid, p == 1);
    chk("r_data", p == 0 ? m0_rdata : m1_rdata, data);
    chk("r_resp", p == 0 ? m0_rresp : m1_rresp, resp);
  endtask

  // Return every outstanding read in order.
  task automatic drain();
    int n;
    n = 0;
    while (exp_port.size() != 0) begin
      s_rvalid = 1'b1;
      s_rid    = 4'(exp_port[0]);
      s_rdata  = 32'hA000_0000 + 32'(n);
      s_rresp  = 2'(n);
      settle();
      rcheck(32'hA000_0000 + 32'(n), 2'(n));
      step();
      n++;
    end
    s_rvalid = 1'b0;
  endtask

  initial begin
`ifdef CRAM_ARB_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    rst = 1'b1;
    m0_araddr = '0; m1_araddr = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b1; s_rdata = '0; s_rid = '0;
    s_rresp = '0; s_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
    settle();
    chk("rst_arvalid", s_arvalid, 0);
    chk("rst_araddr", s_araddr, 0);
    chk("rst_arid", s_arid, 0);
    chk("rst_outst", o_outstanding, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);

    // Single read
    m0_araddr = 32'h10;
    m0_arvalid = 1'b1;
    settle();
    chk("t1_m0_arready", m0_arready, 1);
    exp_port.push_back(0);
    step();
    m0_arvalid = 1'b0;
    settle();
    chk("t1_arvalid", s_arvalid, 1);
    chk("t1_araddr", s_araddr, 32'h10);
    chk("t1_arid", s_arid, 0);
    chk("t1_outst0", o_outstanding, 0);
    step();
    settle();
    chk("t1_arvalid_drop", s_arvalid, 0);
    chk("t1_outst1", o_outstanding, 1);
    s_rvalid = 1'b1;
    s_rid = 4'd0;
    s_rdata = 32'hDEADBEEF;
    s_rresp = 2'b00;
    settle();
    rcheck(32'hDEADBEEF, 2'b00);
    step();
    s_rvalid = 1'b0;
    settle();
    chk("t1_outst_end", o_outstanding, 0);
    chk("t1_err", o_err, 0);

    // Contention, then full FIFO
    do_reset();
    m0_araddr = 32'h100;
    m1_araddr = 32'h200;
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_grant", {m1_arready, m0_arready},
          seq[i] == 1 ? 2'b10 : 2'b01);
      if (i > 0) chk("t2_arid", s_arid, 4'(seq[i-1]));
      exp_port.push_back(seq[i]);
      step();
    end
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    settle();
    chk("t2_arid_last", s_arid, 4'(seq[3]));
    chk("t2_araddr_last", s_araddr, seq[3] == 1 ? 32'h200 : 32'h100);
    step();
    m1_arvalid = 1'b1;
    settle();
    chk("t4_outst_full", o_outstanding, 4);
    chk("t4_m1_arready_full", m1_arready, 0);
    s_rvalid = 1'b1;
    s_rid = 4'(exp_port[0]);
    s_rdata = 32'h1111_0000;
    settle();
    rcheck(32'h1111_0000, 2'b00);
    chk("t4_m1_arready_popcyc", m1_arready, 0);
    step();
    s_rvalid = 1'b0;
    settle();
    chk("t4_outst3", o_outstanding, 3);
    chk("t4_m1_arready_room", m1_arready, 1);
    exp_port.push_back(1);
    step();
    m1_arvalid = 1'b0;
    settle();
    chk("t4_arid", s_arid, 1);
    s_rvalid = 1'b1;
    s_rid = 4'(exp_port[0]);
    s_rdata = 32'h2222_0000;
    settle();
    rcheck(32'h2222_0000, 2'b00);
    step();
    s_rvalid = 1'b0;
    settle();
    chk("t4_push_pop", o_outstanding, 3);
    drain();
    settle();
    chk("t4_drained", o_outstanding, 0);
    chk("t2_err", o_err, 0);

    // AR backpressure
    s_arready = 1'b0;
    m0_araddr = 32'h20;
    m0_arvalid = 1'b1;
    settle();
    chk("t3_grant", m0_arready, 1);
    exp_port.push_back(0);
    step();
    m0_araddr = 32'h24;
    m1_araddr = 32'h44;
    m1_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_addr_hold", s_araddr, 32'h20);
      chk("t3_id_hold", s_arid, 0);
      chk("t3_valid_hold", s_arvalid, 1);
      chk("t3_no_grant", {m1_arready, m0_arready}, 0);
      step();
    end
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    s_arready = 1'b1;
    settle();
    chk("t3_addr_4th", s_araddr, 32'h20);
    step();
    settle();
    chk("t3_hs", s_arvalid, 0);
    chk("t3_outst", o_outstanding, 1);
    drain();

    // R backpressure on port 1
    m1_araddr = 32'h300;
    m1_arvalid = 1'b1;
    settle();
    chk("t6_grant", m1_arready, 1);
    exp_port.push_back(1);
    step();
    m1_arvalid = 1'b0;
    step();
    m1_rready = 1'b0;
    s_rvalid = 1'b1;
    s_rid = 4'd1;
    s_rdata = 32'hCAFE_F00D;
    s_rresp = 2'b10;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t6_m1_rvalid", m1_rvalid, 1);
      chk("t6_rready_low", s_rready, 0);
      chk("t6_no_pop", o_outstanding, 1);
      step();
    end
    m1_rready = 1'b1;
    settle();
    chk("t6_rready_high", s_rready, 1);
    rcheck(32'hCAFE_F00D, 2'b10);
    step();
    s_rvalid = 1'b0;
    s_rresp = 2'b00;
    settle();
    chk("t6_popped", o_outstanding, 0);

    // Routing error, then reset
    m0_araddr = 32'h400;
    m0_arvalid = 1'b1;
    settle();
    exp_port.push_back(0);
    step();
    m0_arvalid = 1'b0;
    step();
    s_rvalid = 1'b1;
    s_rid = 4'd1;
    s_rdata = 32'h5555_AAAA;
    settle();
    rcheck(32'h5555_AAAA, 2'b00);
    step();
    s_rvalid = 1'b0;
    settle();
    chk("t5_err_set", o_err, 1);
    chk("t5_outst", o_outstanding, 0);
    s_arready = 1'b0;
    m0_arvalid = 1'b1;
    step();
    m0_arvalid = 1'b0;
    settle();
    chk("t5_slot_busy", s_arvalid, 1);
    do_reset();
    s_arready = 1'b1;
    settle();
    chk("t5_rst_err", o_err, 0);
    chk("t5_rst_outst", o_outstanding, 0);
    chk("t5_rst_arvalid", s_arvalid, 0);
    s_rvalid = 1'b1;
    s_rid = 4'd0;
    settle();
    chk("t5_stray_rready", s_rready, 1);
    chk("t5_stray_rvalid", {m1_rvalid, m0_rvalid}, 0);
    step();
    s_rvalid = 1'b0;
    settle();
    chk("t5_stray_err", o_err, 1);
    chk("sb_drained", exp_port.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
